// File: rtl/fp_mac_seq_master_if.sv
// Avalon-MM bus bundle for fp_mac_seq_master: memory master port and MAC-slave master port.
interface fp_mac_seq_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_waitrequest;

  logic              acc_chipselect;
  logic [2:0]        acc_address;
  logic              acc_write;
  logic [31:0]       acc_writedata;
  logic              acc_read;
  logic [31:0]       acc_readdata;
  logic              acc_waitrequest;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_waitrequest,
    output acc_chipselect, acc_address, acc_write, acc_writedata, acc_read,
    input  acc_readdata, acc_waitrequest
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_waitrequest,
    input  acc_chipselect, acc_address, acc_write, acc_writedata, acc_read,
    output acc_readdata, acc_waitrequest
  );
endinterface

// File: rtl/fp_mac_seq_master.sv
// Sequencer that streams {A,B,C} records from memory into the fp_mac_dma slave and stores A*B+C.
// Define FP_MAC_SEQ_ACCUM_EN for dot-product mode (previous result fed back as C, one final store).
module fp_mac_seq_master #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [CNT_W-1:0]    count,
  output logic                busy,
  output logic                done,
  fp_mac_seq_master_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, RD_A, WR_A, RD_B, WR_B, RD_C, WR_C, ACC_RD, ACC_WAIT, WR_RES, DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] rec_ptr;
  logic [ADDR_W-1:0] res_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  rec_idx;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              acc_chipselect;
  logic [2:0]        acc_address;
  logic              acc_write;
  logic [31:0]       acc_writedata;
  logic              acc_read;

  logic              last_rec;
  logic              skip_c;
  logic [31:0]       prev_res;
  logic [ADDR_W-1:0] rec_step;

`ifdef FP_MAC_SEQ_ACCUM_EN
  logic [31:0]       res_q;
  // Record 0 is a full {A,B,C} triple; later records are {A,B} pairs.
  assign rec_step = (rec_idx == '0) ? ADDR_W'(12) : ADDR_W'(8);
  assign skip_c   = (rec_idx != '0);
  assign prev_res = res_q;
`else
  assign rec_step = ADDR_W'(12);
  assign skip_c   = 1'b0;
  assign prev_res = 32'd0;
`endif

  assign last_rec = (rec_idx == cnt_q - 1'b1);

  assign bus.mem_address    = mem_address;
  assign bus.mem_read       = mem_read;
  assign bus.mem_write      = mem_write;
  assign bus.mem_writedata  = mem_writedata;
  assign bus.acc_chipselect = acc_chipselect;
  assign bus.acc_address    = acc_address;
  assign bus.acc_write      = acc_write;
  assign bus.acc_writedata  = acc_writedata;
  assign bus.acc_read       = acc_read;

  // All bus strobes are registered and set on entry to the state that owns them,
  // so a request is held untouched for as long as its waitrequest stays high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      acc_chipselect <= 1'b0;
      acc_read       <= 1'b0;
      acc_write      <= 1'b0;
      acc_address    <= '0;
      acc_writedata  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rec_ptr <= src_addr;
          res_ptr <= dst_addr;
          cnt_q   <= count;
          rec_idx <= '0;
          busy    <= 1'b1;
          if (count == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state       <= RD_A;
            mem_read    <= 1'b1;
            mem_address <= src_addr;
          end
        end
        RD_A: if (!bus.mem_waitrequest) begin
          state          <= WR_A;
          mem_read       <= 1'b0;
          acc_chipselect <= 1'b1;
          acc_write      <= 1'b1;
          acc_address    <= 3'd0;
          acc_writedata  <= bus.mem_readdata;
        end
        WR_A: if (!bus.acc_waitrequest) begin
          state          <= RD_B;
          acc_chipselect <= 1'b0;
          acc_write      <= 1'b0;
          mem_read       <= 1'b1;
          mem_address    <= rec_ptr + ADDR_W'(4);
        end
        RD_B: if (!bus.mem_waitrequest) begin
          state          <= WR_B;
          mem_read       <= 1'b0;
          acc_chipselect <= 1'b1;
          acc_write      <= 1'b1;
          acc_address    <= 3'd1;
          acc_writedata  <= bus.mem_readdata;
        end
        WR_B: if (!bus.acc_waitrequest) begin
          if (skip_c) begin
            state         <= WR_C;
            acc_address   <= 3'd2;
            acc_writedata <= prev_res;
          end else begin
            state          <= RD_C;
            acc_chipselect <= 1'b0;
            acc_write      <= 1'b0;
            mem_read       <= 1'b1;
            mem_address    <= rec_ptr + ADDR_W'(8);
          end
        end
        RD_C: if (!bus.mem_waitrequest) begin
          state          <= WR_C;
          mem_read       <= 1'b0;
          acc_chipselect <= 1'b1;
          acc_write      <= 1'b1;
          acc_address    <= 3'd2;
          acc_writedata  <= bus.mem_readdata;
        end
        WR_C: if (!bus.acc_waitrequest) begin
          state       <= ACC_RD;
          acc_write   <= 1'b0;
          acc_read    <= 1'b1;
          acc_address <= 3'd0;
        end
        // The slave's read is a single fixed-latency beat: no waitrequest handshake.
        ACC_RD: begin
          state          <= ACC_WAIT;
          acc_chipselect <= 1'b0;
          acc_read       <= 1'b0;
        end
        ACC_WAIT: begin
`ifdef FP_MAC_SEQ_ACCUM_EN
          if (!last_rec) begin
            state       <= RD_A;
            res_q       <= bus.acc_readdata;
            rec_ptr     <= rec_ptr + rec_step;
            rec_idx     <= rec_idx + 1'b1;
            mem_read    <= 1'b1;
            mem_address <= rec_ptr + rec_step;
          end else
`endif
          begin
            state         <= WR_RES;
            mem_write     <= 1'b1;
            mem_address   <= res_ptr;
            mem_writedata <= bus.acc_readdata;
          end
        end
        WR_RES: if (!bus.mem_waitrequest) begin
          mem_write <= 1'b0;
          res_ptr   <= res_ptr + ADDR_W'(4);
          rec_idx   <= rec_idx + 1'b1;
          if (last_rec) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state       <= RD_A;
            rec_ptr     <= rec_ptr + rec_step;
            mem_read    <= 1'b1;
            mem_address <= rec_ptr + rec_step;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mac_seq_master.sv
// Scoreboard bench for fp_mac_seq_master with a behavioural memory and a table-driven MAC slave.
module tb_fp_mac_seq_master;

  localparam logic [31:0] F0  = 32'h00000000;
  localparam logic [31:0] F1  = 32'h3F800000;
  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F3  = 32'h40400000;
  localparam logic [31:0] F4  = 32'h40800000;
  localparam logic [31:0] F5  = 32'h40A00000;
  localparam logic [31:0] F7  = 32'h40E00000;
  localparam logic [31:0] F13 = 32'h41500000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] count;
  logic        busy;
  logic        done;

  fp_mac_seq_master_if #(.ADDR_W(32)) bus();

  fp_mac_seq_master #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Memory: read-only image indexed by word address bits [9:2]; stores go to the scoreboard.
  logic [31:0] mem_arr [0:255];
  int          mem_stall = 0;
  int          acc_stall = 0;
  int          mem_wcnt  = 0;
  int          acc_wcnt  = 0;

  assign bus.mem_readdata    = mem_arr[bus.mem_address[9:2]];
  assign bus.mem_waitrequest = (bus.mem_read || bus.mem_write) && (mem_wcnt < mem_stall);
  assign bus.acc_waitrequest = bus.acc_chipselect && bus.acc_write && (acc_wcnt < acc_stall);

  always @(posedge clk) begin
    if ((bus.mem_read || bus.mem_write) && bus.mem_waitrequest) mem_wcnt <= mem_wcnt + 1;
    else mem_wcnt <= 0;
    if (bus.acc_chipselect && bus.acc_write && bus.acc_waitrequest) acc_wcnt <= acc_wcnt + 1;
    else acc_wcnt <= 0;
  end

  function automatic logic [31:0] mac_ref(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    case ({a, b, c})
      {F1, F2, F3}: return F5;
      {F2, F3, F1}: return F7;
      {F1, F1, F1}: return F2;
      {F2, F2, F0}: return F4;
      {F2, F3, F7}: return F13;
      default:      return 32'hDEADBEEF;
    endcase
  endfunction

  logic [31:0] ma, mb, mc;
  always @(posedge clk) begin
    if (!reset) begin
      ma <= '0; mb <= '0; mc <= '0;
      bus.acc_readdata <= '0;
    end else begin
      if (bus.acc_chipselect && bus.acc_write && !bus.acc_waitrequest) begin
        case (bus.acc_address)
          3'd0:    ma <= bus.acc_writedata;
          3'd1:    mb <= bus.acc_writedata;
          3'd2:    mc <= bus.acc_writedata;
          default: ;
        endcase
      end
      if (bus.acc_chipselect && bus.acc_read) bus.acc_readdata <= mac_ref(ma, mb, mc);
    end
  end

  logic [63:0] acc_q[$];
  logic [63:0] mem_q[$];

  task automatic push_acc(input logic [2:0] a, input logic [31:0] d);
    acc_q.push_back({29'd0, a, d});
  endtask
  task automatic push_rec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    push_acc(3'd0, a); push_acc(3'd1, b); push_acc(3'd2, c);
  endtask
  task automatic push_mem(input logic [31:0] a, input logic [31:0] d);
    mem_q.push_back({a, d});
  endtask
  task automatic put(input logic [31:0] a, input logic [31:0] d);
    mem_arr[a[9:2]] = d;
  endtask

  // Monitor: pops on every accepted write and checks request stability across stalls.
  logic [65:0] mem_prev;
  logic [38:0] acc_prev;
  bit          mem_stalled = 0;
  bit          acc_stalled = 0;
  logic [63:0] got;
  logic [63:0] want;

  always @(negedge clk) begin
    if (reset) begin
      if (bus.acc_chipselect && bus.acc_write && !bus.acc_waitrequest) begin
        got = {29'd0, bus.acc_address, bus.acc_writedata};
        if (acc_q.size() == 0) chk(1'b0, "acc_unexpected_write", got, 64'd0);
        else begin
          want = acc_q.pop_front();
          chk(got == want, "acc_write", got, want);
        end
      end
      if (bus.mem_write && !bus.mem_waitrequest) begin
        got = {bus.mem_address, bus.mem_writedata};
        if (mem_q.size() == 0) chk(1'b0, "mem_unexpected_write", got, 64'd0);
        else begin
          want = mem_q.pop_front();
          chk(got == want, "mem_write", got, want);
        end
      end
      if (bus.mem_read || bus.mem_write)
        chk(!(bus.mem_read && bus.mem_write), "mem_rw_exclusive", {bus.mem_read, bus.mem_write}, 64'd0);
      if (bus.acc_read || bus.acc_write)
        chk(!(bus.acc_read && bus.acc_write), "acc_rw_exclusive", {bus.acc_read, bus.acc_write}, 64'd0);
      if (mem_stalled)
        chk({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata} == mem_prev,
            "mem_hold", {bus.mem_address, bus.mem_writedata}, mem_prev[63:0]);
      if (acc_stalled)
        chk({bus.acc_chipselect, bus.acc_write, bus.acc_read, bus.acc_address, bus.acc_writedata} == acc_prev,
            "acc_hold", {25'd0, bus.acc_chipselect, bus.acc_write, bus.acc_read, bus.acc_address, bus.acc_writedata},
            {25'd0, acc_prev});
    end
    mem_prev    <= {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata};
    acc_prev    <= {bus.acc_chipselect, bus.acc_write, bus.acc_read, bus.acc_address, bus.acc_writedata};
    mem_stalled <= reset && (bus.mem_read || bus.mem_write) && bus.mem_waitrequest;
    acc_stalled <= reset && bus.acc_chipselect && bus.acc_write && bus.acc_waitrequest;
  end

  function automatic logic [63:0] out_vec();
    return {51'd0, busy, done, bus.mem_read, bus.mem_write, bus.acc_chipselect, bus.acc_read,
            bus.acc_write, bus.acc_address, |bus.mem_address, |bus.mem_writedata, |bus.acc_writedata};
  endfunction

  task automatic run(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] cnt,
                     input int exp_lat, input int repulse, input string nm);
    int cyc;
    bit seen;
    src_addr = src; dst_addr = dst; count = cnt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1; seen = 0;
    chk(busy == 1'b1, {nm, "_busy"}, 64'(busy), 64'd1);
    if (cnt == 16'd0)
      chk({bus.mem_read, bus.mem_write, bus.acc_chipselect} == 3'b000, {nm, "_no_strobe"},
          64'({bus.mem_read, bus.mem_write, bus.acc_chipselect}), 64'd0);
    while (!seen && cyc < 1000) begin
      if (done) seen = 1;
      else begin
        if (cyc == repulse) begin
          start = 1'b1; count = 16'd0; src_addr = 32'h3F0;
        end else start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk(seen && cyc == exp_lat, {nm, "_latency"}, 64'(cyc), 64'(exp_lat));
    @(posedge clk); #1;
    chk({busy, done} == 2'b00, {nm, "_idle_after"}, 64'({busy, done}), 64'd0);
    chk(acc_q.size() == 0 && mem_q.size() == 0, {nm, "_drain"}, 64'(acc_q.size() + mem_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; count = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    put(32'h100, F1); put(32'h104, F2); put(32'h108, F3);
    put(32'h110, F2); put(32'h114, F3); put(32'h118, F1);
    put(32'h11C, F1); put(32'h120, F1); put(32'h124, F1);
    put(32'h128, F2); put(32'h12C, F2); put(32'h130, F0);
    put(32'h140, F1); put(32'h144, F2); put(32'h148, F3);
    put(32'h14C, F2); put(32'h150, F3); put(32'h154, F1);
    put(32'h160, F2); put(32'h164, F3); put(32'h168, F1);
    put(32'h16C, F2); put(32'h170, F3);
    put(32'hFFFFFFF8, F1); put(32'hFFFFFFFC, F1); put(32'h0, F1);
    put(32'h4, F2); put(32'h8, F2); put(32'hC, F0);

    repeat (3) @(posedge clk);
    #1;
    chk(out_vec() == 64'd0, "reset_state", out_vec(), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

`ifdef FP_MAC_SEQ_ACCUM_EN
    push_rec(F2, F3, F1);
    push_rec(F2, F3, F7);
    push_mem(32'h200, F13);
    run(32'h160, 32'h200, 16'd2, 17, 0, "accum2");
    run(32'h100, 32'h200, 16'd0, 1, 0, "count0");
`else
    push_rec(F1, F2, F3);
    push_mem(32'h200, F5);
    run(32'h100, 32'h200, 16'd1, 10, 0, "single");

    mem_stall = 2; acc_stall = 1;
    push_rec(F2, F3, F1); push_mem(32'h210, F7);
    push_rec(F1, F1, F1); push_mem(32'h214, F2);
    push_rec(F2, F2, F0); push_mem(32'h218, F4);
    run(32'h110, 32'h210, 16'd3, 61, 0, "stall3");
    mem_stall = 0; acc_stall = 0;

    run(32'h100, 32'h200, 16'd0, 1, 0, "count0");

    push_rec(F2, F3, F1); push_mem(32'h240, F7);
    push_rec(F1, F1, F1); push_mem(32'h244, F2);
    run(32'h110, 32'h240, 16'd2, 19, 5, "repulse");

    push_rec(F1, F1, F1); push_mem(32'hFFFFFFFC, F2);
    push_rec(F2, F2, F0); push_mem(32'h00000000, F4);
    run(32'hFFFFFFF8, 32'hFFFFFFFC, 16'd2, 19, 0, "wrap");

    // Abort during WR_B of the second record; its B write lands on the reset edge and is dropped.
    begin
      int cyc;
      push_rec(F1, F2, F3); push_mem(32'h220, F5);
      push_acc(3'd0, F2);
      src_addr = 32'h140; dst_addr = 32'h220; count = 16'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cyc = 1;
      while (cyc < 13) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk(bus.acc_write && bus.acc_address == 3'd1 && bus.acc_writedata == F3, "abort_in_wr_b",
          {bus.acc_address, bus.acc_writedata}, {3'd1, F3});
      reset = 1'b0;
      @(posedge clk); #1;
      chk(out_vec() == 64'd0, "abort_outputs", out_vec(), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk(acc_q.size() == 0 && mem_q.size() == 0 && out_vec() == 64'd0, "abort_quiet",
          64'(acc_q.size() + mem_q.size()), 64'd0);
    end

    push_rec(F1, F2, F3);
    push_mem(32'h230, F5);
    run(32'h100, 32'h230, 16'd1, 10, 0, "after_abort");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
